prio_encoder_hs: RTL and testbench

Parametrised registered priority encoder with a valid/ready handshake on both sides. It accepts an N-bit request vector and returns the binary index of the selected bit, plus flags for empty and multi-hot inputs. Selection is either fixed lowest-index priority or round-robin with a rotating pointer. It sits between request-generating logic and an index consumer, such as a mux select or arbiter grant, where one-hot encoding no longer suffices.

---
 rtl/prio_encoder_hs.sv | 99 +++++++++
 tb/tb_prio_encoder_hs.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_hs.sv
// Registered priority encoder with valid/ready handshake on both sides.
// Define PRIO_ENC_RR_EN to add the rr_mode port and round-robin pointer.
module prio_encoder_hs #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
`ifdef PRIO_ENC_RR_EN
    input  logic         rr_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_multi
);

    logic         out_valid_q;
    logic [W-1:0] out_idx_q, idx_d, fix_idx;
    logic         out_none_q, out_multi_q;
    logic         accept, pop;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    // Lowest set bit wins: scan downward so the last hit is the lowest index.
    always_comb begin
        fix_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_req[i]) fix_idx = W'(i);
        end
    end

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d, rr_idx;
    logic         rr_found;
    int           j;

    // Search starts at ptr and wraps at N, which need not be a power of two.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!rr_found && in_req[j]) begin
                rr_idx   = W'(j);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        idx_d = rr_mode ? rr_idx : fix_idx;
        ptr_d = ptr_q;
        if (accept && rr_mode && (in_req != '0)) begin
            ptr_d = (idx_d == W'(N - 1)) ? '0 : idx_d + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        idx_d = fix_idx;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            out_multi_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= idx_d;
            out_none_q  <= (in_req == '0);
            // Clearing the lowest set bit leaves something iff two or more were set.
            out_multi_q <= ((in_req & (in_req - N'(1))) != '0);
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_none  = out_none_q;
    assign out_multi = out_multi_q;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Bench for prio_encoder_hs: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_prio_encoder_hs;
    localparam int N = 4;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_req = '0;
    logic         rr_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_idx;
    logic         out_none;
    logic         out_multi;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prio_encoder_hs #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_req(in_req),
`ifdef PRIO_ENC_RR_EN
        .rr_mode(rr_mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_none(out_none), .out_multi(out_multi)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: result slot plus pointer, updated from rules.
    bit m_valid = 0;
    int m_idx = 0, m_none = 0, m_multi = 0, m_ptr = 0;

    function automatic int pick(input logic [N-1:0] req, input bit rr, input int ptr);
        int start;
        start = rr ? ptr : 0;
        for (int k = 0; k < N; k++)
            if (req[(start + k) % N]) return (start + k) % N;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit rr;
`ifdef PRIO_ENC_RR_EN
        rr = rr_mode;
`else
        rr = 1'b0;
`endif
        if (!rst_n) begin
            m_valid = 0; m_idx = 0; m_none = 0; m_multi = 0; m_ptr = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_idx   = pick(in_req, rr, m_ptr);
            m_none  = (in_req == 0);
            m_multi = ($countones(in_req) >= 2);
            if (rr && in_req != 0) m_ptr = (m_idx + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_valid", int'(out_valid), int'(m_valid));
            chk("cyc_ready", int'(in_ready), int'(!m_valid || out_ready));
            chk("cyc_idx",   int'(out_idx),   m_idx);
            chk("cyc_none",  int'(out_none),  m_none);
            chk("cyc_multi", int'(out_multi), m_multi);
        end
    end

    // Drive inputs, let one edge pass, land 2 time units after it.
    task automatic step(input bit v, input logic [N-1:0] req, input bit ordy, input bit rr);
        in_valid = v; in_req = req; out_ready = ordy; rr_mode = rr;
        @(posedge clk); #2;
    endtask

    task automatic lit(input string nm, input int idx, input int none, input int multi);
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_idx"},   int'(out_idx),   idx);
        chk({nm, "_none"},  int'(out_none),  none);
        chk({nm, "_multi"}, int'(out_multi), multi);
    endtask

    initial begin
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_idx",   int'(out_idx),   0);
        chk("rst_none",  int'(out_none),  0);
        chk("rst_multi", int'(out_multi), 0);
        chk("rst_ready", int'(in_ready),  1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // One-hot sweep
        for (int i = 0; i < N; i++) begin
            logic [N-1:0] r;
            r = '0; r[i] = 1'b1;
            step(1, r, 1, 0);
            lit("onehot", i, 0, 0);
        end

        // Empty and multi-hot
        step(1, 4'b0000, 1, 0); lit("empty", 0, 1, 0);
        step(1, 4'b1010, 1, 0); lit("multi", 1, 0, 1);

        // Backpressure then coincident pop+accept
        step(1, 4'b0100, 1, 0); lit("bp_load", 2, 0, 0);
        in_req = 4'b0001; out_ready = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready", int'(in_ready), 0);
            chk("bp_idx",   int'(out_idx),  2);
            @(posedge clk); #2;
        end
        step(1, 4'b0001, 1, 0); lit("bp_release", 0, 0, 0);

`ifdef PRIO_ENC_RR_EN
        // Round-robin rotation with wrap, then empty leaves the pointer alone
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b1111, 1, 1);
            lit("rr_rot", i % N, 0, 1);
        end
        step(1, 4'b0000, 1, 1); lit("rr_empty", 0, 1, 0);
        step(1, 4'b1111, 1, 1); lit("rr_hold", 1, 0, 1);
        step(1, 4'b1111, 1, 1); lit("rr_after", 2, 0, 1);
        // Reset mid-operation with pending result: pointer returns to 0
        step(1, 4'b0110, 1, 0);
        step(1, 4'b0110, 1, 1);
        lit("rst_pre", 1, 0, 1);
        rst_n = 1'b0;
        step(1, 4'b1111, 0, 1);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_idx",   int'(out_idx),   0);
        chk("midrst_none",  int'(out_none),  0);
        chk("midrst_multi", int'(out_multi), 0);
        rst_n = 1'b1;
        step(1, 4'b1111, 1, 1); lit("rst_post", 0, 0, 1);
`else
        for (int i = 0; i < 4; i++) begin
            step(1, 4'b1111, 1, 0);
            lit("fixed_1111", 0, 0, 1);
        end
        step(1, 4'b0110, 0, 0);
        rst_n = 1'b0;
        step(1, 4'b1111, 0, 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_idx",   int'(out_idx),   0);
        chk("midrst_multi", int'(out_multi), 0);
        rst_n = 1'b1;
        step(1, 4'b1000, 1, 0); lit("rst_post", 3, 0, 0);
`endif

        // Randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(99) != 0);
            step($urandom_range(3) != 0, N'($urandom), $urandom_range(9) < 7,
                 $urandom_range(1) == 1);
        end
        rst_n = 1'b1;
        step(0, '0, 1, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
